wb_local_memory_bridge: RTL and testbench
=========================================

// Module: wb_local_memory_bridge
// PURPOSE
// Wishbone classic (B4, non-pipelined) slave bridging the SoC Wishbone bus onto the local memory
// block's WB-side request port (address/byteSelect/enable/writeEnable/dataWrite, dataRead/busy).
// Latches each bus cycle, holds the local request until busy clears, returns ack or a timeout error.
// Sits between the SoC bus interconnect and the local memory interface of each core.
// PARAMETERS
// BASE_ADDRESS    8'h30  value of wb_adr_i[31:24] selecting this bridge
// TIMEOUT_CYCLES  255    busy cycles tolerated before error (>=2); counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
// clk               in   1   system clock; all logic on posedge
// rst               in   1   synchronous reset, active high
// wb_cyc_i          in   1   bus cycle
// wb_stb_i          in   1   strobe
// wb_we_i           in   1   1=write
// wb_sel_i          in   4   byte select
// wb_adr_i          in   32  byte address
// wb_data_i         in   32  write data
// wb_ack_o          out  1   transfer complete (one cycle)
// wb_error_o        out  1   timeout error (one cycle)
// wb_data_o         out  32  read data
// localAddress      out  24  = latched wb_adr_i[23:0]
// localByteSelect   out  4   latched wb_sel_i
// localEnable       out  1   request valid
// localWriteEnable  out  1   latched wb_we_i
// localDataWrite    out  32  latched wb_data_i
// localDataRead     in   32  read data, valid in the cycle localBusy is low
// localBusy         in   1   local side not done (combinational from localEnable)
// BEHAVIOUR
// - Reset (sync, any state): state=IDLE; every output 0; timeout counter 0; in-flight transfer dropped, no ack/error.
// - States IDLE, ACCESS, ACK, ERROR; all outputs registered or decoded from state only.
// - IDLE: if wb_cyc_i & wb_stb_i & wb_adr_i[31:24]==BASE_ADDRESS at posedge -> latch adr[23:0], sel, we, data;
//   counter<=0; ->ACCESS. Non-matching address: ignored, no response (another slave owns it).
// - ACCESS: localEnable=1, local* outputs = latched values, stable for the whole state; bus inputs ignored.
//   At each posedge, priority order:
//   1) !wb_cyc_i -> abort to IDLE, no ack, no error.
//   2) !localBusy -> if read, wb_data_o<=localDataRead; ->ACK.
//   3) localBusy & counter==TIMEOUT_CYCLES-1 -> wb_data_o<=32'hFFFF_FFFF; ->ERROR.
//   4) else counter<=counter+1.
// - ACK: wb_ack_o=1, localEnable=0, exactly one cycle -> IDLE. ERROR: wb_error_o=1 one cycle -> IDLE.
// - ack and error mutually exclusive; never both; never more than one per accepted strobe.
// - Latency (strobe sampled at edge N, no contention): write ack high in cycle N+2; read (local busy
//   1 cycle) ack in N+3 with data. Each extra busy cycle adds one.
// - Error raised after exactly TIMEOUT_CYCLES consecutive busy ACCESS cycles; ERROR state is the next cycle.
// - wb_data_o holds last captured value; unchanged by writes/aborts; reset 0.
// - Addresses beyond the SRAM range go through unchanged; the local side answers them not-busy with
//   all-ones read data, which the bridge returns with a normal ack.
// - Back-to-back: new strobe is accepted in IDLE the cycle after ACK/ERROR (one idle cycle minimum).
// - local* data/address registers hold last latched values outside ACCESS; only localEnable qualifies.
// TESTING
// 1 Write: adr 32'h3000_0010, sel 4'hF, dat 32'hDEAD_BEEF, we=1, busy=0 -> localEnable 1 cycle,
//   localAddress 24'h000010, localDataWrite DEADBEEF; wb_ack_o high in cycle N+2 only.
// 2 Read: busy=1 first ACCESS cycle, then 0 with localDataRead 32'h1234_5678 -> wb_data_o 12345678,
//   ack in N+3; sel 4'h3 passed as localByteSelect 4'h3.
// 3 Contention: write with localBusy held 5 cycles -> localEnable/address stable 6 cycles, ack 1 cycle after.
// 4 Timeout: TIMEOUT_CYCLES=8, busy stuck -> wb_error_o one cycle after 8 busy cycles, wb_data_o FFFFFFFF,
//   no ack; next strobe accepted normally.
// 5 Abort/reset: drop wb_cyc_i or assert rst in ACCESS -> IDLE next cycle, localEnable 0, no ack/error.
// 6 Decode: adr 32'h3100_0000 with cyc/stb held 10 cycles -> localEnable never asserted, no ack/error.

Source files
------------

// File: rtl/wb_local_memory_bridge.sv
// wb_local_memory_bridge
// Wishbone classic (non-pipelined) slave that forwards one bus cycle at a
// time onto the local memory block's request port. The request is latched at
// acceptance and held until the local side drops localBusy. The bus then gets
// a one-cycle ack, or a one-cycle error if the local side stays busy too long.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i  bus cycle / strobe
//   wb_we_i, wb_sel_i   write enable, byte selects
//   wb_adr_i, wb_data_i byte address (upper byte decoded), write data
//   wb_ack_o, wb_error_o one-cycle completion / timeout error
//   wb_data_o           last captured read data (all-ones after a timeout)
//   local*              latched request towards the memory block
//   localDataRead       local read data, valid while localBusy is low
//   localBusy           local side not yet done with the request
//
// state  | meaning
// IDLE   | waiting for a strobe addressed to this bridge
// ACCESS | request presented on the local port, waiting for !localBusy
// ACK    | one-cycle wb_ack_o
// ERROR  | one-cycle wb_error_o after the busy timeout
module wb_local_memory_bridge #(
    parameter logic [7:0] BASE_ADDRESS   = 8'h30,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_data_i,
    output logic        wb_ack_o,
    output logic        wb_error_o,
    output logic [31:0] wb_data_o,
    output logic [23:0] localAddress,
    output logic [3:0]  localByteSelect,
    output logic        localEnable,
    output logic        localWriteEnable,
    output logic [31:0] localDataWrite,
    input  logic [31:0] localDataRead,
    input  logic        localBusy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ACK,
        ST_ERROR
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] timeout_cnt;
    logic          accept;
    logic          timeout_hit;

    assign accept      = wb_cyc_i && wb_stb_i && (wb_adr_i[31:24] == BASE_ADDRESS);
    assign timeout_hit = (timeout_cnt == TC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort on !wb_cyc_i wins over completion; completion wins over timeout,
    // so a request finishing on the last allowed cycle still gets an ack.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!wb_cyc_i) begin
                    state_next = ST_IDLE;
                end else if (!localBusy) begin
                    state_next = ST_ACK;
                end else if (timeout_hit) begin
                    state_next = ST_ERROR;
                end
            end
            ST_ACK:   state_next = ST_IDLE;
            ST_ERROR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt      <= '0;
            localAddress     <= '0;
            localByteSelect  <= '0;
            localWriteEnable <= 1'b0;
            localDataWrite   <= '0;
            wb_data_o        <= '0;
        end else begin
            if (state == ST_IDLE && accept) begin
                localAddress     <= wb_adr_i[23:0];
                localByteSelect  <= wb_sel_i;
                localWriteEnable <= wb_we_i;
                localDataWrite   <= wb_data_i;
                timeout_cnt      <= '0;
            end
            if (state == ST_ACCESS && wb_cyc_i) begin
                if (!localBusy) begin
                    if (!localWriteEnable) begin
                        wb_data_o <= localDataRead;
                    end
                end else if (timeout_hit) begin
                    wb_data_o <= 32'hFFFF_FFFF;
                end else begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
            end
        end
    end

    assign localEnable = (state == ST_ACCESS);
    assign wb_ack_o    = (state == ST_ACK);
    assign wb_error_o  = (state == ST_ERROR);

endmodule

// File: tb/tb_wb_local_memory_bridge.sv
module tb_wb_local_memory_bridge;

    localparam int T = 8;

    logic        clk;
    logic        rst;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_data_i;
    logic        wb_ack_o;
    logic        wb_error_o;
    logic [31:0] wb_data_o;
    logic [23:0] localAddress;
    logic [3:0]  localByteSelect;
    logic        localEnable;
    logic        localWriteEnable;
    logic [31:0] localDataWrite;
    logic [31:0] localDataRead;
    logic        localBusy;

    wb_local_memory_bridge #(
        .BASE_ADDRESS  (8'h30),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wb_cyc_i        (wb_cyc_i),
        .wb_stb_i        (wb_stb_i),
        .wb_we_i         (wb_we_i),
        .wb_sel_i        (wb_sel_i),
        .wb_adr_i        (wb_adr_i),
        .wb_data_i       (wb_data_i),
        .wb_ack_o        (wb_ack_o),
        .wb_error_o      (wb_error_o),
        .wb_data_o       (wb_data_o),
        .localAddress    (localAddress),
        .localByteSelect (localByteSelect),
        .localEnable     (localEnable),
        .localWriteEnable(localWriteEnable),
        .localDataWrite  (localDataWrite),
        .localDataRead   (localDataRead),
        .localBusy       (localBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Local memory model: busy for the first busy_req cycles of each request.
    int busy_req;
    int access_cnt;
    always @(posedge clk) begin
        if (localEnable) access_cnt <= access_cnt + 1;
        else             access_cnt <= 0;
    end
    assign localBusy = localEnable && (access_cnt < busy_req);

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          total;
    int          passed;
    int          fails;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic [31:0] rdata, input int busy);
        exp_t e;
        int   k;
        int   en_cnt;
        logic stable_ok;
        logic got;
        e.err  = (busy >= T);
        e.lat  = e.err ? T + 1 : 2 + busy;
        e.data = e.err ? 32'hFFFF_FFFF : (we ? last_rd : rdata);
        last_rd = e.data;
        sb.push_back(e);

        busy_req      = busy;
        localDataRead = rdata;
        wb_we_i   = we;
        wb_sel_i  = sel;
        wb_adr_i  = adr;
        wb_data_i = dat;
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;

        k = 0; en_cnt = 0; stable_ok = 1'b1; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (localEnable) begin
                en_cnt++;
                if (localAddress !== adr[23:0] || localByteSelect !== sel ||
                    localWriteEnable !== we || localDataWrite !== dat)
                    stable_ok = 1'b0;
            end
            if (wb_ack_o || wb_error_o) got = 1'b1;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;

        check({tag, "_response_seen"}, 32'(got), 32'd1);
        e = sb.pop_front();
        check({tag, "_error"},   32'(wb_error_o), 32'(e.err));
        check({tag, "_ack"},     32'(wb_ack_o), 32'(!e.err));
        check({tag, "_latency"}, 32'(k), 32'(e.lat));
        check({tag, "_enable_cycles"}, 32'(en_cnt), 32'(e.lat - 1));
        check({tag, "_request_stable"}, 32'(stable_ok), 32'd1);
        check({tag, "_rdata"}, wb_data_o, e.data);
        @(negedge clk);
        check({tag, "_single_cycle_resp"}, 32'(wb_ack_o | wb_error_o), 32'd0);
        check({tag, "_enable_after"}, 32'(localEnable), 32'd0);
    endtask

    initial begin
        int   hits;
        total = 0; passed = 0; fails = 0; last_rd = '0;
        busy_req = 0;
        rst = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_sel_i = '0; wb_adr_i = '0; wb_data_i = '0;
        localDataRead = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_ack",    32'(wb_ack_o), 32'd0);
        check("reset_error",  32'(wb_error_o), 32'd0);
        check("reset_rdata",  wb_data_o, 32'd0);
        check("reset_enable", 32'(localEnable), 32'd0);
        check("reset_addr",   32'(localAddress), 32'd0);
        check("reset_wdata",  localDataWrite, 32'd0);

        xfer("write",       1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 32'h0,         0);
        xfer("read",        1'b0, 4'h3, 32'h3000_0020, 32'h0,         32'h1234_5678, 1);
        xfer("contention",  1'b1, 4'hC, 32'h3000_0104, 32'hCAFE_F00D, 32'h0,         5);
        xfer("near_limit",  1'b0, 4'hF, 32'h3000_0200, 32'h0,         32'h0BAD_C0DE, T - 1);
        xfer("timeout",     1'b0, 4'hF, 32'h3000_0300, 32'h0,         32'h5555_AAAA, 1000);
        xfer("after_err_w", 1'b1, 4'h1, 32'h3000_0304, 32'h0000_00A5, 32'h0,         0);
        xfer("after_err_r", 1'b0, 4'hF, 32'h3000_0308, 32'h0,         32'hA5A5_5A5A, 0);
        xfer("beyond_sram", 1'b0, 4'hF, 32'h30FF_FFF0, 32'h0,         32'hFFFF_FFFF, 0);

        // Abort by dropping wb_cyc_i mid-access
        busy_req = 1000;
        wb_we_i = 1'b1; wb_sel_i = 4'hF; wb_adr_i = 32'h3000_0400; wb_data_i = 32'h1111_2222;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_enable_during", 32'(localEnable), 32'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        check("abort_enable_after", 32'(localEnable), 32'd0);
        hits = 0;
        repeat (4) begin
            if (wb_ack_o || wb_error_o) hits++;
            @(negedge clk);
        end
        check("abort_no_response", 32'(hits), 32'd0);
        check("abort_rdata_kept",  wb_data_o, last_rd);

        // Reset asserted mid-access
        wb_we_i = 1'b0; wb_adr_i = 32'h3000_0500;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        localDataRead = 32'h7777_8888;
        repeat (2) @(negedge clk);
        check("rst_enable_during", 32'(localEnable), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        last_rd = '0;
        check("rst_enable_after", 32'(localEnable), 32'd0);
        check("rst_rdata_cleared", wb_data_o, 32'd0);
        check("rst_addr_cleared",  32'(localAddress), 32'd0);
        hits = 0;
        repeat (4) begin
            if (wb_ack_o || wb_error_o) hits++;
            @(negedge clk);
        end
        check("rst_no_response", 32'(hits), 32'd0);

        // Decode miss held for 10 cycles
        busy_req = 0;
        wb_we_i = 1'b1; wb_adr_i = 32'h3100_0000; wb_data_i = 32'h9999_9999;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (localEnable || wb_ack_o || wb_error_o) hits++;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check("decode_miss_activity", 32'(hits), 32'd0);

        xfer("final_write", 1'b1, 4'hF, 32'h3000_0600, 32'h0F0F_0F0F, 32'h0, 2);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
